// File: rtl/alu_arbiter_if.sv
// Requester, response and alu-side signals shared between alu_arbiter and its environment.
// The slave modport is the arbiter's view; the master modport is the requesters-plus-alu view.
interface alu_arbiter_if #(
    parameter int N    = 8,
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*3-1:0] req_func;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [N-1:0]      rsp_data;
    logic [3:0]        rsp_flags;
    logic [N-1:0]      alu_a;
    logic [N-1:0]      alu_b;
    logic [2:0]        alu_func;
    logic [N-1:0]      alu_out;
    logic [3:0]        alu_flags;

    modport slave (
        input  req_valid, req_a, req_b, req_func, rsp_ready, alu_out, alu_flags,
        output req_ready, rsp_valid, rsp_data, rsp_flags, alu_a, alu_b, alu_func
    );

    modport master (
        output req_valid, req_a, req_b, req_func, rsp_ready, alu_out, alu_flags,
        input  req_ready, rsp_valid, rsp_data, rsp_flags, alu_a, alu_b, alu_func
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational alu among NREQ requesters; optional grant_cnt_o under ALU_ARB_STATS_EN.
// Accept at t, response valid at t+2, held until the granted requester's rsp_ready; one op in flight.
module alu_arbiter #(
    parameter int N    = 8,
    parameter int NREQ = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    alu_arbiter_if.slave      bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt_o
`endif
);
    localparam int         GW     = $clog2(NREQ);
    localparam logic [2:0] F_RNOP = 3'b010;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]  gnt_q, gnt_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic [2:0]     func_q, func_d;
    logic [N-1:0]   data_q, data_d;
    logic [3:0]     flags_q, flags_d;

    logic           found;
    logic [GW-1:0]  gsel;
    int             idx;

    // Search from rr_ptr upward with wrap; the first pending requester wins.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                gsel  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        a_d           = a_q;
        b_d           = b_q;
        func_d        = func_q;
        data_d        = data_q;
        flags_d       = flags_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_func  = F_RNOP;
        case (state_q)
            IDLE: begin
                if (found && !reset_i) begin
                    bus.req_ready[gsel] = 1'b1;
                    gnt_d   = gsel;
                    a_d     = bus.req_a[int'(gsel)*N +: N];
                    b_d     = bus.req_b[int'(gsel)*N +: N];
                    func_d  = bus.req_func[int'(gsel)*3 +: 3];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                bus.alu_a    = a_q;
                bus.alu_b    = b_q;
                bus.alu_func = func_q;
                data_d       = bus.alu_out;
                flags_d      = bus.alu_flags;
                state_d      = RESP;
            end
            RESP: begin
                bus.rsp_valid[gnt_q] = 1'b1;
                if (bus.rsp_ready[gnt_q]) begin
                    rr_ptr_d = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rsp_data  = data_q;
    assign bus.rsp_flags = flags_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            func_q   <= F_RNOP;
            data_q   <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            func_q   <= func_d;
            data_q   <= data_d;
            flags_q  <= flags_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [NREQ*16-1:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i]) begin
                grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural alu and a response scoreboard.
module tb_alu_arbiter;
    localparam logic [2:0] C_RA   = 3'b000;
    localparam logic [2:0] C_RB   = 3'b001;
    localparam logic [2:0] C_RNOP = 3'b010;
    localparam logic [2:0] C_RADD = 3'b011;
    localparam logic [2:0] C_RSUB = 3'b100;
    localparam logic [2:0] C_RMUL = 3'b101;

    typedef struct {
        int         gnt;
        logic [7:0] d;
        logic [3:0] fl;
    } exp_t;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    logic [7:0] last_d;
    logic [3:0] last_f;

    alu_arbiter_if #(.N(8), .NREQ(2)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [31:0] grant_cnt;
`endif

    alu_arbiter #(.N(8), .NREQ(2)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt_o (grant_cnt)
`endif
    );

    always #5 clock_i = ~clock_i;

    // Returns {V,N,Z,C, out}.
    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        logic [7:0]  r;
        logic        c, v;
        logic [8:0]  w;
        logic [15:0] p;
        r = 8'h00; c = 1'b0; v = 1'b0; w = 9'h000; p = 16'h0000;
        case (f)
            C_RA: r = a;
            C_RB: r = b;
            C_RADD: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0]; c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            C_RSUB: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[7:0]; c = w[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            C_RMUL: begin
                p = 16'(a) * 16'(b);
                r = p[7:0]; c = |p[15:8];
            end
            C_RNOP: return 12'h000;
            default: return {4'b0010, 8'h00};
        endcase
        return {v, r[7], (r == 8'h00), c, r};
    endfunction

    always_comb {bus.alu_flags, bus.alu_out} = alu_f(bus.alu_a, bus.alu_b, bus.alu_func);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic push_exp(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
        exp_t x;
        x.gnt = idx;
        {x.fl, x.d} = alu_f(a, b, f);
        sb.push_back(x);
    endtask

    task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] f, input int hold);
        int   n;
        exp_t e;
        e = '{0, 8'h00, 4'h0};
        bus.req_a[idx*8 +: 8]    = a;
        bus.req_b[idx*8 +: 8]    = b;
        bus.req_func[idx*3 +: 3] = f;
        bus.req_valid[idx]       = 1'b1;
        #1;
        n = 0;
        while (bus.req_ready[idx] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("grant_cycle0", 32'(n), 32'(0));
        chk("req_ready_onehot", 32'(bus.req_ready), 32'(1) << idx);
        push_exp(idx, a, b, f);
        tick();
        bus.req_valid[idx] = 1'b0;
        #1;
        chk("exec_alu_func", 32'(bus.alu_func), 32'(f));
        chk("exec_alu_a", 32'(bus.alu_a), 32'(a));
        chk("exec_no_rsp", 32'(bus.rsp_valid), 32'(0));
        tick();
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            chk("rsp_valid_t2", 32'(bus.rsp_valid), 32'(1) << e.gnt);
            chk("rsp_data", 32'(bus.rsp_data), 32'(e.d));
            chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.fl));
        end
        last_d = bus.rsp_data;
        last_f = bus.rsp_flags;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", 32'(bus.rsp_valid), 32'(1) << idx);
            chk("hold_data", 32'(bus.rsp_data), 32'(e.d));
        end
        bus.rsp_ready[idx] = 1'b1;
        tick();
        bus.rsp_ready[idx] = 1'b0;
        #1;
        chk("rsp_released", 32'(bus.rsp_valid), 32'(0));
    endtask

    initial begin
        logic [7:0] oa [2];
        logic [7:0] ob [2];
        logic [2:0] of [2];
        int         ng, nr, g;
        exp_t       e;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_func  = '0;
        bus.rsp_ready = '0;
        tick();
        tick();
        reset_i = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'(0));
        chk("rst_rsp_flags", 32'(bus.rsp_flags), 32'(0));
        chk("rst_alu_func", 32'(bus.alu_func), 32'(C_RNOP));
        chk("rst_alu_a", 32'(bus.alu_a), 32'(0));

        do_op(0, 8'h7F, 8'h01, C_RADD, 0);
        chk("add_data", 32'(last_d), 32'h80);
        chk("add_flags", 32'(last_f), 32'b1100);

        bus.rsp_ready[0] = 1'b1;
        do_op(1, 8'h05, 8'h05, C_RSUB, 5);
        bus.rsp_ready[0] = 1'b0;
        chk("sub_data", 32'(last_d), 32'h00);
        chk("sub_flags", 32'(last_f), 32'b0010);

        do_op(0, 8'h03, 8'h04, C_RMUL, 0);
        chk("mul_data", 32'(last_d), 32'h0C);
        chk("mul_flags", 32'(last_f), 32'b0000);

        do_op(1, 8'h12, 8'h34, 3'b111, 1);
        chk("unk_data", 32'(last_d), 32'h00);
        chk("unk_flags", 32'(last_f), 32'b0010);

        do_op(0, 8'hAA, 8'h55, C_RB, 0);
        chk("rb_data", 32'(last_d), 32'h55);

        // Both requesters pending from reset: expect strict alternation starting at 0.
        oa[0] = 8'h10; ob[0] = 8'h20; of[0] = C_RADD;
        oa[1] = 8'h50; ob[1] = 8'h08; of[1] = C_RSUB;
        reset_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.req_a[i*8 +: 8]    = oa[i];
            bus.req_b[i*8 +: 8]    = ob[i];
            bus.req_func[i*3 +: 3] = of[i];
        end
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        tick();
        chk("rst_ready_gated", 32'(bus.req_ready), 32'(0));
        tick();
        reset_i = 1'b0;
        #1;
        ng = 0;
        nr = 0;
        for (int cyc = 0; cyc < 40 && nr < 4; cyc++) begin
            if (bus.req_ready != 2'b00) begin
                g = int'(bus.req_ready[1]);
                chk("rr_order", 32'(g), 32'(ng % 2));
                push_exp(g, oa[g], ob[g], of[g]);
                ng++;
            end
            if (bus.rsp_valid != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("rr_sb_underflow", 32'(0), 32'(1));
                end else begin
                    e = sb.pop_front();
                    chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.gnt);
                    chk("rr_rsp_data", 32'(bus.rsp_data), 32'(e.d));
                    chk("rr_rsp_flags", 32'(bus.rsp_flags), 32'(e.fl));
                end
                nr++;
            end
            tick();
            if (ng >= 4) begin
                bus.req_valid = 2'b00;
                #1;
            end
        end
        chk("rr_all_served", 32'(nr), 32'(4));
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;

        // Reset during EXEC abandons the op and returns the pointer to 0.
        do_op(0, 8'h3C, 8'h00, C_RA, 0);
        chk("ra_data", 32'(last_d), 32'h3C);
        bus.req_a = {8'h09, 8'h01};
        bus.req_b = {8'h03, 8'h01};
        bus.req_func = {C_RSUB, C_RADD};
        bus.req_valid = 2'b11;
        #1;
        chk("rr_after_req0", 32'(bus.req_ready), 32'b10);
        tick();
        reset_i = 1'b1;
        #1;
        chk("exec_before_rst", 32'(bus.alu_func), 32'(C_RSUB));
        tick();
        reset_i = 1'b0;
        #1;
        chk("rst_exec_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        chk("rst_exec_alu_func", 32'(bus.alu_func), 32'(C_RNOP));
        chk("rst_exec_alu_a", 32'(bus.alu_a), 32'(0));
        chk("rst_exec_rsp_data", 32'(bus.rsp_data), 32'(0));
        chk("rst_exec_rr_ptr0", 32'(bus.req_ready), 32'b01);
        bus.req_valid = 2'b00;
        #1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("abandoned_no_rsp", 32'(bus.rsp_valid), 32'(0));
        end

`ifdef ALU_ARB_STATS_EN
        for (int i = 0; i < 3; i++) do_op(0, 8'(i), 8'h01, C_RADD, 0);
        for (int i = 0; i < 2; i++) do_op(1, 8'(i), 8'h01, C_RSUB, 0);
        chk("grant_cnt", grant_cnt, {16'd2, 16'd3});
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
        chk("grant_cnt_rst", grant_cnt, 32'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
